// File: rtl/voxel_gpu_ctrl.sv
// voxel_gpu_ctrl: register front-end plus clear-pass fill engine; define VOXEL_GPU_PERF_EN to add the render_cycles counter
module voxel_gpu_ctrl #(
  parameter logic [31:0] DEFAULT_BUFFER = 32'h0800_0000,
  parameter int H_RESOLUTION = 256,
  parameter int V_RESOLUTION = 192,
  parameter int PIXEL_BYTES = 2,
  parameter int CAM_REGS = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  s1_address,
  input  logic [31:0] s1_writedata,
  input  logic        s1_write,
  output logic [31:0] s1_readdata,
  output logic        s1_waitrequest,
  output logic [31:0] m1_address,
  output logic [31:0] m1_writedata,
  output logic [3:0]  m1_byteenable,
  output logic        m1_write,
  output logic        m1_read,
  input  logic        m1_waitrequest,
  input  logic [31:0] m1_readdata,
  input  logic        m1_readdatavalid,
  output logic        irq
);
  typedef enum logic {IDLE, FILL} state_t;
  localparam logic [31:0] LAST = 32'(H_RESOLUTION * V_RESOLUTION - 1);
  localparam logic [31:0] STEP = 32'(PIXEL_BYTES);
  state_t state, state_nxt;
  logic [31:0] pixel_buffer, clear_color, pixels_written, addr;
  logic [31:0] cam [CAM_REGS];
  logic irq_pending, ctl_wr, start, clear_irq, accept, last, unused;
  assign ctl_wr = s1_write && s1_address == 8'h0f;
  assign start = ctl_wr && |s1_writedata && state == IDLE;
  assign clear_irq = ctl_wr && ~|s1_writedata;
  assign accept = m1_write && !m1_waitrequest;
  assign last = accept && pixels_written == LAST;
  assign irq = irq_pending;
  assign s1_waitrequest = 1'b0;
  assign m1_read = 1'b0;
  assign unused = ^{m1_readdata, m1_readdatavalid};
  // state register; reset abandons any fill at once
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // next state and master-port outputs, all zero while idle
  always_comb begin
    state_nxt = start ? FILL : last ? IDLE : state;
    m1_write = state == FILL;
    m1_address = m1_write ? addr : '0;
    m1_writedata = !m1_write ? '0 : PIXEL_BYTES == 4 ? clear_color : {2{clear_color[15:0]}};
    m1_byteenable = !m1_write ? '0 : PIXEL_BYTES == 4 ? 4'hf : addr[1] ? 4'hc : 4'h3;
  end
  // config registers, fill address/count and completion interrupt; completion beats a same-cycle clear
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      pixel_buffer <= DEFAULT_BUFFER;
      clear_color <= '0;
      addr <= '0;
      pixels_written <= '0;
      irq_pending <= 1'b0;
    end else begin
      if (s1_write && s1_address == 8'h00) pixel_buffer <= s1_writedata;
      if (s1_write && s1_address == 8'h01) clear_color <= s1_writedata;
      if (start) begin
        addr <= pixel_buffer;
        pixels_written <= '0;
      end else if (accept) begin
        addr <= addr + STEP;
        pixels_written <= pixels_written + 32'd1;
      end
      irq_pending <= start ? 1'b0 : last ? 1'b1 : clear_irq ? 1'b0 : irq_pending;
    end
  // camera scratch registers
  always_ff @(posedge clock or posedge reset)
    for (int i = 0; i < CAM_REGS; i++)
      if (reset) cam[i] <= '0;
      else if (s1_write && s1_address == 8'(16 + i)) cam[i] <= s1_writedata;
`ifdef VOXEL_GPU_PERF_EN
  logic [31:0] render_cycles;
  // saturating count of fill cycles, stalls included
  always_ff @(posedge clock or posedge reset)
    if (reset) render_cycles <= '0;
    else if (start) render_cycles <= '0;
    else if (state == FILL && ~&render_cycles) render_cycles <= render_cycles + 32'd1;
`endif
  // combinational register readback
  always_comb begin
    s1_readdata = '0;
    case (s1_address)
      8'h00: s1_readdata = pixel_buffer;
      8'h01: s1_readdata = clear_color;
      8'h02: s1_readdata = {30'b0, irq_pending, state == FILL};
      8'h03: s1_readdata = pixels_written;
`ifdef VOXEL_GPU_PERF_EN
      8'h05: s1_readdata = render_cycles;
`endif
      default: s1_readdata = (s1_address[7:4] == 4'h1 && {28'b0, s1_address[3:0]} < CAM_REGS) ? cam[s1_address[3:0]] : '0;
    endcase
  end
endmodule

// File: tb/tb_voxel_gpu_ctrl.sv
// tb_voxel_gpu_ctrl: scoreboard bench driving a 4-byte and a 2-byte instance
module tb_voxel_gpu_ctrl;
  logic clock = 0, reset = 1;
  always #5 clock = ~clock;
  int n_chk = 0, n_fail = 0, a_acc = 0, b_acc = 0;
  bit b_rand = 0;
  logic [67:0] qa[$], qb[$];
  logic [7:0] a_ad = 0, b_ad = 0;
  logic [31:0] a_wd = 0, b_wd = 0, a_rd, b_rd, a_ma, b_ma, a_md, b_md;
  logic a_wr = 0, b_wr = 0, a_sw, b_sw, a_mw, b_mw, a_mr, b_mr, a_irq, b_irq;
  logic a_wait = 0, b_wait = 0;
  logic [3:0] a_be, b_be;
  voxel_gpu_ctrl #(.H_RESOLUTION(4), .V_RESOLUTION(2), .PIXEL_BYTES(4)) dut_a (
    .clock(clock), .reset(reset), .s1_address(a_ad), .s1_writedata(a_wd), .s1_write(a_wr),
    .s1_readdata(a_rd), .s1_waitrequest(a_sw), .m1_address(a_ma), .m1_writedata(a_md),
    .m1_byteenable(a_be), .m1_write(a_mw), .m1_read(a_mr), .m1_waitrequest(a_wait),
    .m1_readdata(32'h0), .m1_readdatavalid(1'b0), .irq(a_irq));
  voxel_gpu_ctrl #(.H_RESOLUTION(4), .V_RESOLUTION(2), .PIXEL_BYTES(2)) dut_b (
    .clock(clock), .reset(reset), .s1_address(b_ad), .s1_writedata(b_wd), .s1_write(b_wr),
    .s1_readdata(b_rd), .s1_waitrequest(b_sw), .m1_address(b_ma), .m1_writedata(b_md),
    .m1_byteenable(b_be), .m1_write(b_mw), .m1_read(b_mr), .m1_waitrequest(b_wait),
    .m1_readdata(32'h0), .m1_readdatavalid(1'b0), .irq(b_irq));
  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wr(input bit s, input logic [7:0] ad, input logic [31:0] d);
    @(posedge clock); #1;
    if (s) begin b_ad = ad; b_wd = d; b_wr = 1; end
    else begin a_ad = ad; a_wd = d; a_wr = 1; end
    @(posedge clock); #1;
    a_wr = 0; b_wr = 0;
  endtask
  task automatic rd(input bit s, input logic [7:0] ad, input logic [31:0] exp, input string name);
    if (s) b_ad = ad; else a_ad = ad;
    #1 chk(name, s ? b_rd : a_rd, exp);
  endtask
  // random stalls on the 2-byte instance
  always @(posedge clock) begin
    #1 b_wait = b_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  end
  // monitor for instance a: stalled beats must already match the head, accepted beats pop it
  always @(negedge clock)
    if (a_mw) begin
      if (qa.size() == 0) chk("a_unexpected_write", {a_ma, a_md, a_be}, 68'h0);
      else begin
        chk("a_beat", {a_ma, a_md, a_be}, qa[0]);
        if (!a_wait) begin void'(qa.pop_front()); a_acc++; end
      end
    end
  // monitor for instance b
  always @(negedge clock)
    if (b_mw) begin
      if (qb.size() == 0) chk("b_unexpected_write", {b_ma, b_md, b_be}, 68'h0);
      else begin
        chk("b_beat", {b_ma, b_md, b_be}, qb[0]);
        if (!b_wait) begin void'(qb.pop_front()); b_acc++; end
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 0;
    rd(0, 8'h00, 32'h0800_0000, "rst_buffer");
    rd(0, 8'h01, 32'h0, "rst_color");
    rd(0, 8'h02, 32'h0, "rst_status");
    rd(0, 8'h10, 32'h0, "rst_cam0");
    rd(0, 8'h05, 32'h0, "perf_absent");
    chk("rst_irq", a_irq, 0);
    chk("rst_m1_write", a_mw, 0);
    wr(0, 8'h1b, 32'h55);
    rd(0, 8'h1b, 32'h55, "cam_last");
    wr(0, 8'h1c, 32'h77);
    rd(0, 8'h1c, 32'h0, "cam_out_of_range");
    // 4-byte fill without stalls
    for (int i = 0; i < 8; i++) qa.push_back({32'h100 + 32'(4 * i), 32'hAABBCCDD, 4'hf});
    wr(0, 8'h00, 32'h100);
    wr(0, 8'h01, 32'hAABBCCDD);
    rd(0, 8'h00, 32'h100, "buffer_rb");
    wr(0, 8'h0f, 32'h1);
    rd(0, 8'h02, 32'h1, "a_busy_first");
    repeat (7) @(posedge clock);
    #1 rd(0, 8'h02, 32'h1, "a_busy_last");
    @(posedge clock); #1;
    chk("a_irq_done", a_irq, 1);
    rd(0, 8'h02, 32'h2, "a_status_done");
    rd(0, 8'h03, 32'h8, "a_pixels");
    chk("a_queue_empty", qa.size(), 0);
    chk("a_idle_outputs", {a_mw, a_ma, a_md, a_be}, 0);
    rd(0, 8'h0f, 32'h0, "control_reads_0");
    wr(0, 8'h0f, 32'h0);
    chk("a_irq_cleared", a_irq, 0);
    // 2-byte fill with random stalls
    b_rand = 1;
    for (int i = 0; i < 8; i++) qb.push_back({32'h200 + 32'(2 * i), 32'h12341234, (i % 2) ? 4'hc : 4'h3});
    wr(1, 8'h00, 32'h200);
    wr(1, 8'h01, 32'h1234);
    wr(1, 8'h0f, 32'h5);
    for (int i = 0; i < 200 && !b_irq; i++) begin @(posedge clock); #1; end
    chk("b_irq_done", b_irq, 1);
    b_rand = 0;
    rd(1, 8'h03, 32'h8, "b_pixels");
    chk("b_queue_empty", qb.size(), 0);
    chk("b_acceptances", b_acc, 8);
    wr(1, 8'h0f, 32'h0);
    // start while busy ignored, clear colliding with final acceptance loses
    for (int i = 0; i < 8; i++) qa.push_back({32'h100 + 32'(4 * i), 32'hAABBCCDD, 4'hf});
    wr(0, 8'h0f, 32'h1);
    wr(0, 8'h0f, 32'h3);
    repeat (5) @(posedge clock);
    #1 a_ad = 8'h0f; a_wd = 0; a_wr = 1;
    @(posedge clock);
    #1 a_wr = 0;
    chk("collision_irq", a_irq, 1);
    rd(0, 8'h03, 32'h8, "collision_pixels");
    rd(0, 8'h02, 32'h2, "collision_status");
    chk("a_queue_empty2", qa.size(), 0);
    chk("a_acceptances", a_acc, 16);
    wr(0, 8'h0f, 32'h0);
    chk("a_irq_cleared2", a_irq, 0);
    // reset in the middle of a fill
    for (int i = 0; i < 3; i++) qb.push_back({32'h200 + 32'(2 * i), 32'h12341234, (i % 2) ? 4'hc : 4'h3});
    wr(1, 8'h0f, 32'h1);
    repeat (3) @(posedge clock);
    #1 reset = 1;
    #1 chk("reset_m1_write", b_mw, 0);
    rd(1, 8'h02, 32'h0, "reset_status");
    rd(1, 8'h03, 32'h0, "reset_pixels");
    repeat (2) @(posedge clock);
    #1 reset = 0;
    repeat (10) @(posedge clock);
    #1 chk("reset_no_more_writes", b_mw, 0);
    chk("b_queue_empty2", qb.size(), 0);
    chk("b_acceptances2", b_acc, 11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/voxel_gpu_ctrl.md
# voxel_gpu_ctrl

Parametrised successor to the GPU register front-end. It adds a real clear-pass render engine behind the same Avalon-MM slave register file. A render command fills the H×V pixel buffer with a programmable clear colour through the Avalon-MM master, obeys `m1_waitrequest`, reports progress and busy status, and raises a level interrupt on completion. It sits between the HPS bridge (s1) and SDRAM (m1). It is the first stage onto which voxel rasterisation will later be added.

## Interface
- `DEFAULT_BUFFER`, 32'h0800_0000, reset value of `pixel_buffer`
- `H_RESOLUTION`, 256, pixels per line
- `V_RESOLUTION`, 192, lines per frame
- `PIXEL_BYTES`, 2, bytes per pixel; legal values 2 or 4
- `CAM_REGS`, 12, number of camera scratch registers at 0x10 upward; 1..16

Ports:
- `clock`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `s1_address`  in  8  word register address
- `s1_writedata`  in  32  write data
- `s1_write`  in  1  write strobe
- `s1_readdata`  out  32  read data, combinational from `s1_address`
- `s1_waitrequest`  out  1  tied 0
- `m1_address`  out  32  byte address
- `m1_writedata`  out  32  pixel data
- `m1_byteenable`  out  4  lanes written
- `m1_write`  out  1  write request
- `m1_read`  out  1  tied 0
- `m1_waitrequest`  in  1  slave stall
- `m1_readdata`  in  32  unused
- `m1_readdatavalid`  in  1  unused
- `irq`  out  1  equals `irq_pending`

## Operation
Register map:
- 0x00 `pixel_buffer`: RW, reset `DEFAULT_BUFFER`.
- 0x01 `clear_color`: RW, reset 0. Only the low 8·`PIXEL_BYTES` bits are used.
- 0x02 `status`: RO. Bit0 = busy (state ≠ IDLE), bit1 = `irq_pending`, other bits 0.
- 0x03 `pixels_written`: RO. Pixels accepted in the current or last fill.
- 0x0f `control`: WO, reads 0. A nonzero write is a start. A zero write clears `irq_pending`.
- 0x10 .. 0x10+`CAM_REGS`-1: RW camera registers, reset 0.
- All other addresses read 0 and ignore writes.

FSM states are IDLE and FILL.
- **IDLE → FILL on start:**
  - Latch `pixel_buffer` into `addr`.
  - Set `pixels_written` to 0.
  - Clear `irq_pending`.
- **Start while in FILL:** ignored.
- **FILL behaviour:**
  - `m1_write` is 1 and `m1_address` = `addr`.
  - When `PIXEL_BYTES`=4: `m1_writedata` = `clear_color`, `m1_byteenable` = 4'b1111.
  - When `PIXEL_BYTES`=2: `m1_writedata` = {`clear_color`[15:0], `clear_color`[15:0]}. `m1_byteenable` = `addr`[1] ? 4'b1100 : 4'b0011.
- **Write accepted** (`m1_write` & !`m1_waitrequest`):
  - `addr` += `PIXEL_BYTES`.
  - `pixels_written` += 1.
  - If this was pixel H·V-1: go to IDLE and set `irq_pending`.
- **During a stall:** address, data and byteenable are held stable.
- **Writes to `pixel_buffer`/`clear_color` during FILL:** the register updates. The fill in flight keeps its latched address. The new colour takes effect on the next accepted pixel.
- **Clear-interrupt write in the same cycle as final acceptance:** completion wins, and `irq_pending` = 1.
- **Reset:** all outputs and registers return to reset values. `m1_write`=0, `m1_address`=0, `m1_writedata`=0, `m1_byteenable`=0, `irq`=0, state IDLE.
- **Reset mid-fill:** abandons the fill immediately. No further m1 writes occur.
- **Outputs in IDLE:** `m1_address`, `m1_writedata` and `m1_byteenable` are 0.

## Timing
- A start write sampled at edge N gives `m1_write`=1 from cycle N+1.
- Throughput is one pixel per cycle when `m1_waitrequest`=0. The fill takes H·V + stall cycles.
- `irq`, busy=0 and the final `pixels_written` = H·V are all visible the cycle after the last acceptance.
- Register writes take effect at the next edge. Readback of the same address is visible the following cycle.
- `pixels_written` is 32 bits wide. `addr` wraps modulo 2^32.

## Configuration
- `VOXEL_GPU_PERF_EN` defined:
  - Adds RO register 0x05 `render_cycles`, 32-bit and saturating.
  - It is cleared on start and increments every FILL cycle, including stalls.
  - It holds its value in IDLE. Reset value is 0.
- Undefined: 0x05 reads 0 and no counter logic is present.

## Test plan
- **Reset readback:** reset, then read 0x00/0x01/0x02/0x10 → 0x0800_0000/0/0/0, with `irq`=0 and `m1_write`=0.
- **4-byte fill, no stalls:** H=4, V=2, `PIXEL_BYTES`=4, buffer 0x100, colour 0xAABBCCDD, start.
  - Expect 8 consecutive writes to 0x100..0x11C, data 0xAABBCCDD, byteenable 1111.
  - `irq`=1 one cycle after the 8th, `pixels_written`=8.
  - Writing 0 to 0x0f drops `irq` next cycle.
- **2-byte fill with stalls:** `PIXEL_BYTES`=2, colour 0x1234, random `m1_waitrequest`.
  - Addresses step by 2 and byteenable alternates 0011/1100.
  - Data is 0x12341234.
  - Outputs are stable during stalls; exactly H·V acceptances occur.
- **Start while busy, clear collision:** issue a second start mid-fill → ignored and the count is unaffected. Clear-interrupt on the final-acceptance cycle → `irq` stays 1.
- **Reset mid-fill:** assert reset after 3 acceptances → `m1_write`=0 immediately, status=0, no further writes after release.
- **Perf counter:** with `VOXEL_GPU_PERF_EN`, 8-pixel fill plus 5 stall cycles → 0x05 reads 13. Without the macro, 0x05 reads 0.
